// File: rtl/ptw_sched.sv
`default_nettype none
// ============================================================================
// Module      : ptw_sched
// Description : Shared Sv39/Sv48 page-table walker for ITLB and DTLB misses.
//               Round-robin arbitration, one 64-bit PTE read port, TLB fill
//               or page-fault report on completion.
//               Optional macro PTW_AD_CHECK_EN: software-managed A/D bits
//               (A=0 leaf faults, store to D=0 leaf faults).
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_sched #(
    parameter int PAGING_LEVELS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [43:0] root_ppn,
    input  logic        i_miss,
    input  logic [63:0] i_va,
    input  logic        d_miss,
    input  logic [63:0] d_va,
    input  logic        d_store,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_data,
    output logic        i_done,
    output logic        d_done,
    output logic        fault,
    output logic        replace_i,
    output logic        replace_d,
    output logic [63:0] replace_va,
    output logic [63:0] replace_pa,
    output logic        replace_dirty,
    output logic        replace_readable,
    output logic        replace_writable
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;          // 1: DTLB wins the next tie
    logic        side_q, side_d;      // 0: ITLB walk, 1: DTLB walk
    logic [63:0] va_q, va_d;
    logic        store_q, store_d;
    logic [43:0] ppn_q, ppn_d;
    logic [1:0]  level_q, level_d;
    logic [63:0] pte_q, pte_d;
    logic        abort_q, abort_d;
    logic        mem_req_q, mem_req_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic        fault_q, fault_d;
    logic        replace_i_q, replace_i_d;
    logic        replace_d_q, replace_d_d;
    logic [63:0] replace_va_q, replace_va_d;
    logic [63:0] replace_pa_q, replace_pa_d;
    logic        dirty_q, dirty_d;
    logic        readable_q, readable_d;
    logic        writable_q, writable_d;

    // PTE field decode and address arithmetic for the current level
    logic [5:0]  w_shift;
    logic [8:0]  w_vpn;
    logic [63:0] w_pte_addr;
    logic [43:0] w_mask;
    logic [43:0] w_pte_ppn;
    logic [43:0] w_leaf_ppn;
    logic        w_invalid, w_nonleaf, w_misaligned, w_ad_fault;
    logic        w_abort, w_grant_d;
    logic        w_finish, w_fail, w_fill;
    logic        w_unused_bits;

    assign w_shift    = 6'd12 + 6'(level_q) * 6'd9;
    assign w_vpn      = 9'(va_q >> w_shift);
    assign w_pte_addr = {8'b0, ppn_q, 12'b0} + {52'b0, w_vpn, 3'b0};
    assign w_mask     = (44'd1 << (6'(level_q) * 6'd9)) - 44'd1;
    assign w_pte_ppn  = pte_q[53:10];
    // Superpage: upper PPN bits from the PTE, lower VPN bits pass through
    assign w_leaf_ppn = (w_pte_ppn & ~w_mask) | (va_q[55:12] & w_mask);

    assign w_invalid    = !pte_q[0] || (pte_q[2] && !pte_q[1]);
    assign w_nonleaf    = !pte_q[1] && !pte_q[3];
    assign w_misaligned = |(w_pte_ppn & w_mask);
`ifdef PTW_AD_CHECK_EN
    assign w_ad_fault   = !pte_q[6] || (store_q && !pte_q[7]);
`else
    assign w_ad_fault   = 1'b0;
`endif
    assign w_abort       = abort_q || clear;
    assign w_unused_bits = ^{pte_q[63:54], pte_q[9:8], pte_q[6:4], store_q};

    // Walk sequencing and registered output computation
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        side_d       = side_q;
        va_d         = va_q;
        store_d      = store_q;
        ppn_d        = ppn_q;
        level_d      = level_q;
        pte_d        = pte_q;
        abort_d      = abort_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        fault_d      = 1'b0;
        replace_i_d  = 1'b0;
        replace_d_d  = 1'b0;
        replace_va_d = replace_va_q;
        replace_pa_d = replace_pa_q;
        dirty_d      = dirty_q;
        readable_d   = readable_q;
        writable_d   = writable_q;
        w_grant_d    = 1'b0;
        w_finish     = 1'b0;
        w_fail       = 1'b0;
        w_fill       = 1'b0;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (i_miss || d_miss) begin
                    w_grant_d = d_miss && (!i_miss || rr_q);
                    side_d    = w_grant_d;
                    rr_d      = !w_grant_d;
                    va_d      = w_grant_d ? d_va : i_va;
                    store_d   = w_grant_d && d_store;
                    ppn_d     = root_ppn;
                    level_d   = 2'(PAGING_LEVELS - 1);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Nothing is outstanding yet, so an abort ends the walk here
                if (w_abort) begin
                    w_finish = 1'b1;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = w_pte_addr;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                abort_d = w_abort;
                if (mem_ack) begin
                    pte_d     = mem_data;
                    mem_req_d = 1'b0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_abort) begin
                    w_finish = 1'b1;
                end else if (w_invalid) begin
                    w_finish = 1'b1;
                    w_fail   = 1'b1;
                end else if (w_nonleaf) begin
                    if (level_q == 2'd0) begin
                        w_finish = 1'b1;
                        w_fail   = 1'b1;
                    end else begin
                        level_d = level_q - 2'd1;
                        ppn_d   = w_pte_ppn;
                        state_d = S_ISSUE;
                    end
                end else if (w_misaligned || w_ad_fault) begin
                    w_finish = 1'b1;
                    w_fail   = 1'b1;
                end else begin
                    w_finish = 1'b1;
                    w_fill   = 1'b1;
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (w_finish) begin
            i_done_d = !side_q;
            d_done_d = side_q;
            fault_d  = w_fail;
            state_d  = S_DONE;
            if (w_fill) begin
                replace_i_d  = !side_q;
                replace_d_d  = side_q;
                replace_va_d = va_q;
                replace_pa_d = {8'b0, w_leaf_ppn, 12'b0};
                readable_d   = pte_q[1];
                writable_d   = pte_q[2];
                dirty_d      = pte_q[7];
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_q         <= 1'b0;
            side_q       <= 1'b0;
            va_q         <= 64'd0;
            store_q      <= 1'b0;
            ppn_q        <= 44'd0;
            level_q      <= 2'd0;
            pte_q        <= 64'd0;
            abort_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 64'd0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            fault_q      <= 1'b0;
            replace_i_q  <= 1'b0;
            replace_d_q  <= 1'b0;
            replace_va_q <= 64'd0;
            replace_pa_q <= 64'd0;
            dirty_q      <= 1'b0;
            readable_q   <= 1'b0;
            writable_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            side_q       <= side_d;
            va_q         <= va_d;
            store_q      <= store_d;
            ppn_q        <= ppn_d;
            level_q      <= level_d;
            pte_q        <= pte_d;
            abort_q      <= abort_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            fault_q      <= fault_d;
            replace_i_q  <= replace_i_d;
            replace_d_q  <= replace_d_d;
            replace_va_q <= replace_va_d;
            replace_pa_q <= replace_pa_d;
            dirty_q      <= dirty_d;
            readable_q   <= readable_d;
            writable_q   <= writable_d;
        end
    end

    assign mem_req          = mem_req_q;
    assign mem_addr         = mem_addr_q;
    assign i_done           = i_done_q;
    assign d_done           = d_done_q;
    assign fault            = fault_q;
    assign replace_i        = replace_i_q;
    assign replace_d        = replace_d_q;
    assign replace_va       = replace_va_q;
    assign replace_pa       = replace_pa_q;
    assign replace_dirty    = dirty_q;
    assign replace_readable = readable_q;
    assign replace_writable = writable_q;

endmodule
`default_nettype wire
